// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, port ids.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Bytes touched by an access; 0 for the illegal size code.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_nbytes = 3'd1;
            SIZE_HALF: size_nbytes = 3'd2;
            SIZE_WORD: size_nbytes = 3'd4;
            default:   size_nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant records the port served most recently.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_a,
    input  logic  req_b,
    input  logic  update,
    input  port_e served,
    output port_e grant,
    output logic  valid
);

    port_e last_grant;

    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
        end else if (update) begin
            last_grant <= served;
        end
    end

    always_comb begin
        grant = PORT_A;
        if (req_a && req_b) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

    assign valid = req_a | req_b;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port byte-addressed data memory.
// Define ALIGN_CHECK_EN to reject misaligned half/word accesses instead of passing them through.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state;
    port_e             port_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    port_e             grant;
    logic              arb_valid;

    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W:0]   end_addr;
    logic              range_bad;
    logic              align_bad;
    logic              sel_err;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_a  (a_req),
        .req_b  (b_req),
        .update (state == ST_RESP),
        .served (port_q),
        .grant  (grant),
        .valid  (arb_valid)
    );

    always_comb begin
        if (grant == PORT_B) begin
            sel_we    = b_we;
            sel_size  = b_size;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end else begin
            sel_we    = a_we;
            sel_size  = a_size;
            sel_addr  = a_addr;
            sel_wdata = a_wdata;
        end
    end

    // One extra bit so addresses near the top of the space cannot wrap past the check.
    assign end_addr  = {1'b0, sel_addr} + (ADDR_W+1)'(size_nbytes(sel_size));
    assign range_bad = end_addr > (ADDR_W+1)'(MEM_BYTES);

`ifdef ALIGN_CHECK_EN
    assign align_bad = ((sel_size == SIZE_HALF) && sel_addr[0]) ||
                       ((sel_size == SIZE_WORD) && (sel_addr[1:0] != 2'b00));
`else
    assign align_bad = 1'b0;
`endif

    assign sel_err = (sel_size == SIZE_ILL) || range_bad || align_bad;

    // Strobes and acks are registered so they line up exactly with ACCESS and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            port_q    <= PORT_A;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        port_q    <= grant;
                        we_q      <= sel_we;
                        size_q    <= sel_size;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        err_q     <= sel_err;
                        mem_read  <= !sel_err && !sel_we;
                        mem_write <= !sel_err && sel_we;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    a_ack <= (port_q == PORT_A);
                    b_ack <= (port_q == PORT_B);
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_size  = (state == ST_ACCESS) ? size_q  : 2'b00;
    assign mem_addr  = (state == ST_ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state == ST_ACCESS) ? wdata_q : '0;

    // Read data is only meaningful for a successful load during its ack cycle.
    assign a_err   = a_ack & err_q;
    assign b_err   = b_ack & err_q;
    assign a_rdata = (a_ack && !we_q && !err_q) ? mem_rdata : '0;
    assign b_rdata = (b_ack && !we_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural 256-byte memory.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_BYTES = 256;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [1:0]        a_size = 2'b00;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [1:0]        b_size = 2'b00;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              a_ack, a_err, b_ack, b_err;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              mem_read, mem_write;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit strobe_seen = 1'b0;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_size    (a_size),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_size    (b_size),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural memory: little-endian, write at posedge, registered sign-extended read.
    logic [7:0]  mem [MEM_BYTES];
    logic [31:0] mv;
    initial for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;

    function automatic int nb(input logic [1:0] s);
        return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < nb(mem_size); i++)
                mem[(int'(mem_addr[7:0]) + i) % MEM_BYTES] = mem_wdata[8*i +: 8];
        end
        if (mem_read) begin
            for (int i = 0; i < 4; i++)
                mv[8*i +: 8] = mem[(int'(mem_addr[7:0]) + i) % MEM_BYTES];
            case (mem_size)
                SZ_B:    mem_rdata <= {{24{mv[7]}}, mv[7:0]};
                SZ_H:    mem_rdata <= {{16{mv[15]}}, mv[15:0]};
                default: mem_rdata <= mv;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer plus per-cycle output invariants.
    always @(negedge clk) begin
        exp_t e;
        if (mem_read || mem_write) begin
            strobe_seen = 1'b1;
            chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
        end
        if (!a_ack) chk("a_idle_outs", {a_rdata[30:0], a_err}, 32'd0);
        if (!b_ack) chk("b_idle_outs", {b_rdata[30:0], b_err}, 32'd0);
        if (a_ack || b_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'b0, a_ack, b_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {30'b0, a_ack, b_ack}, e.port ? 32'd1 : 32'd2);
                chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                chk("ack_err", {31'b0, e.port ? b_err : a_err}, {31'b0, e.err});
                chk("ack_rdata", e.port ? b_rdata : a_rdata, e.rdata);
            end
        end
    end

    task automatic push_exp(input bit port, input bit err, input logic [31:0] rdata,
                            input int ack_cyc);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rdata; e.ack_cyc = ack_cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input bit port, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            b_req = 1'b1; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
        end
    endtask

    // Bounded wait for the port's ack, then release req in the following cycle.
    task automatic wait_ack(input string tag, input bit port);
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = port ? b_ack : a_ack;
        end
        chk({"ack_seen_", tag}, {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (port) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    task automatic do_acc(input string tag, input bit port, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit exp_err, input logic [31:0] exp_rdata);
        strobe_seen = 1'b0;
        drive(port, we, size, addr, wdata);
        push_exp(port, exp_err, exp_rdata, cyc + 2);
        wait_ack(tag, port);
        if (exp_err) chk({"no_strobe_", tag}, {31'b0, strobe_seen}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000ns");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acks", {30'b0, a_ack, b_ack}, 32'd0);
        chk("rst_errs", {30'b0, a_err, b_err}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_acc("a_st_w", 1'b0, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_acc("a_ld_w", 1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Fresh reset so last_grant is B again; then A reissues while B still waits.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
        drive(1'b1, 1'b1, SZ_W, 32'h20, 32'h12345678);
        c = cyc;
        push_exp(1'b0, 1'b0, 32'hDEADBEEF, c + 2);
        push_exp(1'b1, 1'b0, 32'h0, c + 5);
        wait_ack("cont_a1", 1'b0);
        drive(1'b0, 1'b0, SZ_W, 32'h20, 32'h0);
        push_exp(1'b0, 1'b0, 32'h12345678, c + 8);
        wait_ack("cont_b", 1'b1);
        wait_ack("cont_a2", 1'b0);

        do_acc("b_ld_b", 1'b1, 1'b0, SZ_B, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF);
        do_acc("b_ld_h", 1'b1, 1'b0, SZ_H, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD);
        do_acc("a_st_b", 1'b0, 1'b1, SZ_B, 32'h30, 32'hFFFFFF7F, 1'b0, 32'h0);
        do_acc("a_st_h", 1'b0, 1'b1, SZ_H, 32'h32, 32'hAAAA8001, 1'b0, 32'h0);
        do_acc("a_ld_w30", 1'b0, 1'b0, SZ_W, 32'h30, 32'h0, 1'b0, 32'h8001007F);
        do_acc("a_ld_b30", 1'b0, 1'b0, SZ_B, 32'h30, 32'h0, 1'b0, 32'h0000007F);
        do_acc("b_ld_h32", 1'b1, 1'b0, SZ_H, 32'h32, 32'h0, 1'b0, 32'hFFFF8001);

        do_acc("a_w_fd", 1'b0, 1'b0, SZ_W, 32'hFD, 32'h0, 1'b1, 32'h0);
        do_acc("a_w_fc", 1'b0, 1'b0, SZ_W, 32'hFC, 32'h0, 1'b0, 32'h0);
        do_acc("a_b_ff", 1'b0, 1'b0, SZ_B, 32'hFF, 32'h0, 1'b0, 32'h0);
        do_acc("a_h_ff", 1'b0, 1'b0, SZ_H, 32'hFF, 32'h0, 1'b1, 32'h0);
        do_acc("a_size_ill", 1'b0, 1'b0, SZ_X, 32'h10, 32'h0, 1'b1, 32'h0);
        do_acc("b_wrap", 1'b1, 1'b0, SZ_B, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0);
        do_acc("a_st_ill", 1'b0, 1'b1, SZ_X, 32'h10, 32'h0, 1'b1, 32'h0);
        do_acc("b_st_range", 1'b1, 1'b1, SZ_W, 32'hFE, 32'h11111111, 1'b1, 32'h0);
        do_acc("a_ld_intact", 1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Reset while the load is in ACCESS: strobe drops at once, no ack follows.
        drive(1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_access_read", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("async_rst_acks", {30'b0, a_ack, b_ack}, 32'd0);
        a_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_acc("a_reissue", 1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

`ifdef ALIGN_CHECK_EN
        do_acc("a_w_mis", 1'b0, 1'b0, SZ_W, 32'h11, 32'h0, 1'b1, 32'h0);
        do_acc("b_h_mis", 1'b1, 1'b0, SZ_H, 32'h13, 32'h0, 1'b1, 32'h0);
`else
        strobe_seen = 1'b0;
        do_acc("a_w_mis", 1'b0, 1'b0, SZ_W, 32'h11, 32'h0, 1'b0, 32'h00DEADBE);
        chk("mis_strobe", {31'b0, strobe_seen}, 32'd1);
        do_acc("b_h_mis", 1'b1, 1'b0, SZ_H, 32'h13, 32'h0, 1'b0, 32'h000000DE);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
